pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, flush, and an optional two-entry skid buffer. It replaces the fixed-field, unclocked inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one clocked block. Each pipeline boundary instantiates it with its own payload and control widths. A flushed or empty stage always presents a bubble whose control bits are all zero, so a bubble never writes the register file or memory.

## Interface
- PAYLOAD_W, 97: datapath payload width; EX/MEM packs ir[31:0], aluout[31:0], rt[31:0], zero.
- CTRL_W, 6: control-bit width; EX/MEM packs {MemtoReg, MemRead, MemWrite, RegWrite, branch, jump}.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- STALL_CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_payload  in  PAYLOAD_W  upstream datapath fields.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts this cycle; a hazard unit drives it low to stall.
- out_payload  out  PAYLOAD_W  datapath fields of the head entry.
- out_ctrl  out  CTRL_W  control bits of the head entry; all zero whenever out_valid=0.
- flush  in  1  discard all entries, for a branch or jump taken.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept happens when in_valid && in_ready. Release happens when out_valid && out_ready.
- Priority per cycle: rst, then flush, then normal accept/release.
- rst result on the next edge: out_valid=0, out_ctrl=0, out_payload=0, skid empty, stall_cnt=0, in_ready=1.
- flush result on the next edge: both entries invalid, out_ctrl=0, in_ready=1.
  - An entry offered in the same cycle as flush is dropped.
  - out_payload keeps its value and is don't-care.
  - stall_cnt is not cleared.
- SKID=0 (single register):
  - in_ready = !out_valid || out_ready, combinational.
  - On accept, the main register loads the input.
  - Release without accept clears out_valid.
- SKID=1 (main register plus skid register):
  - in_ready = !skid_valid, registered.
  - Accept while main is empty or releasing: the input goes to main.
  - Accept while main is full and not releasing: the input goes to skid.
  - Release while skid is full: skid moves to main, and skid clears.
- States for SKID=1: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY goes to ONE on accept.
  - ONE goes to TWO on accept without release.
  - ONE goes to EMPTY on release without accept.
  - ONE stays ONE on accept with release, and main loads the new entry.
  - TWO goes to ONE on release; no accept is possible because in_ready=0.
  - Any state goes to EMPTY on flush or rst.
- Order is strictly FIFO. No entry is duplicated or lost except through flush.
- stall_cnt increments by 1 in each cycle where out_valid && !out_ready && !flush. It saturates at 2^STALL_CNT_W-1 and does not wrap.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N, in both modes.
- Throughput is 1 entry per cycle while out_ready=1.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has exactly that path.
- All outputs are registered except in_ready in SKID=0 mode.
- out_ctrl is gated by out_valid inside the block: it equals the stored control bits AND out_valid.
- A flush asserted during a stall takes effect at the next edge, regardless of out_ready.
- rst asserted mid-stream takes effect at the next edge. All stored entries are lost.

## Structure
- Shared package pipe_pkg holds:
  - localparams for the per-boundary widths: IFID_PAYLOAD_W, IDEX_PAYLOAD_W, EXMEM_PAYLOAD_W=97, MEMWB_PAYLOAD_W.
  - localparams for the control widths.
  - localparam bit indices of the control bits: CTRL_JUMP=0, CTRL_BRANCH=1, CTRL_REGWRITE=2, CTRL_MEMWRITE=3, CTRL_MEMREAD=4, CTRL_MEMTOREG=5.
  - the skid-state encoding.
- One sub-module, sat_counter, implements the parametrised saturating stall counter.
- A generate block selects the SKID=0 or SKID=1 datapath.

## Test plan
- Streaming: rst, then 8 entries with out_ready=1 (payload=i, ctrl=6'h3F) -> out_valid and payload=i one cycle after each accept; in_ready stays 1; stall_cnt=0.
- Skid fill, SKID=1: accept A; set out_ready=0; accept B -> in_ready=0 after B and C is held off. Raise out_ready -> A then B released in order, no loss; stall_cnt equals the number of stalled cycles.
- Flush in TWO state: entries A and B held, flush=1 with in_valid=1 for C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; A, B and C never appear.
- Bubble control: empty stage with in_ctrl=6'h0C driven and in_valid=0 -> out_ctrl=0, so MemWrite and RegWrite are never seen high.
- Saturation: STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
- Reset mid-operation and SKID=0: rst during a stall -> next cycle all outputs 0 and in_ready=1. With SKID=0, check in_ready follows out_ready in the same cycle when full.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, control-bit indices and skid-state encoding for the
// inter-stage pipeline registers.
package pipe_pkg;

   // Payload widths per pipeline boundary
   localparam int IFID_PAYLOAD_W  = 64;   // pc4, ir
   localparam int IDEX_PAYLOAD_W  = 160;  // ir, pc4, rs, rt, imm
   localparam int EXMEM_PAYLOAD_W = 97;   // ir, aluout, rt, zero
   localparam int MEMWB_PAYLOAD_W = 96;   // ir, aluout, memdata

   // Control widths per pipeline boundary
   localparam int IFID_CTRL_W  = 1;
   localparam int IDEX_CTRL_W  = 9;
   localparam int EXMEM_CTRL_W = 6;
   localparam int MEMWB_CTRL_W = 2;

   // Bit positions inside the EX/MEM control vector
   localparam int CTRL_JUMP     = 0;
   localparam int CTRL_BRANCH   = 1;
   localparam int CTRL_REGWRITE = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_MEMTOREG = 5;

   // Occupancy of the two-entry skid datapath
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, hold at all-ones, clear on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Clocked pipeline stage register with valid/ready handshake, flush,
// bubble-gated control bits and an optional two-entry skid buffer.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W   = EXMEM_PAYLOAD_W,
   parameter int CTRL_W      = EXMEM_CTRL_W,
   parameter int SKID        = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   input  logic [CTRL_W-1:0]      in_ctrl,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PAYLOAD_W-1:0]   out_payload,
   output logic [CTRL_W-1:0]      out_ctrl,
   input  logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic                 head_valid;
   logic [PAYLOAD_W-1:0] head_payload;
   logic [CTRL_W-1:0]    head_ctrl;
   logic                 stall_inc;

   generate
      if (SKID == 0) begin : g_single
         logic                 valid_q;
         logic [PAYLOAD_W-1:0] payload_q;
         logic [CTRL_W-1:0]    ctrl_q;
         logic                 accept;

         assign in_ready = !valid_q || out_ready;
         assign accept   = in_valid && in_ready;

         // Single register: load on accept, empty on release without refill
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q   <= 1'b0;
               payload_q <= '0;
               ctrl_q    <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
               ctrl_q  <= '0;
            end else if (accept) begin
               valid_q   <= 1'b1;
               payload_q <= in_payload;
               ctrl_q    <= in_ctrl;
            end else if (valid_q && out_ready) begin
               valid_q <= 1'b0;
            end
         end

         assign head_valid   = valid_q;
         assign head_payload = payload_q;
         assign head_ctrl    = ctrl_q;
      end else begin : g_skid
         skid_state_t          state;
         logic [PAYLOAD_W-1:0] main_payload, skid_payload;
         logic [CTRL_W-1:0]    main_ctrl, skid_ctrl;
         logic                 ready_q;
         logic                 accept;

         assign accept = in_valid && ready_q;

         // Main/skid occupancy FSM; in_ready is registered and drops only in TWO
         always_ff @(posedge clk) begin
            if (rst) begin
               state        <= SKID_EMPTY;
               main_payload <= '0;
               main_ctrl    <= '0;
               skid_payload <= '0;
               skid_ctrl    <= '0;
               ready_q      <= 1'b1;
            end else if (flush) begin
               state     <= SKID_EMPTY;
               main_ctrl <= '0;
               skid_ctrl <= '0;
               ready_q   <= 1'b1;
            end else begin
               case (state)
                  SKID_EMPTY: begin
                     if (accept) begin
                        main_payload <= in_payload;
                        main_ctrl    <= in_ctrl;
                        state        <= SKID_ONE;
                     end
                  end
                  SKID_ONE: begin
                     if (accept && out_ready) begin
                        main_payload <= in_payload;
                        main_ctrl    <= in_ctrl;
                     end else if (accept) begin
                        skid_payload <= in_payload;
                        skid_ctrl    <= in_ctrl;
                        state        <= SKID_TWO;
                        ready_q      <= 1'b0;
                     end else if (out_ready) begin
                        state <= SKID_EMPTY;
                     end
                  end
                  SKID_TWO: begin
                     if (out_ready) begin
                        main_payload <= skid_payload;
                        main_ctrl    <= skid_ctrl;
                        state        <= SKID_ONE;
                        ready_q      <= 1'b1;
                     end
                  end
                  default: begin
                     state   <= SKID_EMPTY;
                     ready_q <= 1'b1;
                  end
               endcase
            end
         end

         assign in_ready     = ready_q;
         assign head_valid   = (state != SKID_EMPTY);
         assign head_payload = main_payload;
         assign head_ctrl    = main_ctrl;
      end
   endgenerate

   assign out_valid   = head_valid;
   assign out_payload = head_payload;
   assign out_ctrl    = head_ctrl & {CTRL_W{head_valid}};

   assign stall_inc = head_valid && !out_ready && !flush;

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance and a SKID=0 instance with a
// 4-bit stall counter share stimulus; each is checked against a queue model.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [96:0] in_payload = '0;
   logic [5:0]  in_ctrl = '0;

   logic        s1_in_ready, s1_out_valid;
   logic [96:0] s1_out_payload;
   logic [5:0]  s1_out_ctrl;
   logic [15:0] s1_stall;

   logic        s0_in_ready, s0_out_valid;
   logic [96:0] s0_out_payload;
   logic [5:0]  s0_out_ctrl;
   logic [3:0]  s0_stall;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(97), .CTRL_W(6), .SKID(1), .STALL_CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
      .in_payload(in_payload), .in_ctrl(in_ctrl), .out_valid(s1_out_valid),
      .out_ready(out_ready), .out_payload(s1_out_payload), .out_ctrl(s1_out_ctrl),
      .flush(flush), .stall_cnt(s1_stall)
   );

   pipe_stage_reg #(.PAYLOAD_W(97), .CTRL_W(6), .SKID(0), .STALL_CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready),
      .in_payload(in_payload), .in_ctrl(in_ctrl), .out_valid(s0_out_valid),
      .out_ready(out_ready), .out_payload(s0_out_payload), .out_ctrl(s0_out_ctrl),
      .flush(flush), .stall_cnt(s0_stall)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [96:0] p;
      logic [5:0]  c;
   } ent_t;

   // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (single)
   ent_t        q1[$];
   ent_t        q0[$];
   int unsigned cnt1 = 0;
   int unsigned cnt0 = 0;

   typedef struct {
      bit          r, f, iv, orr;
      logic [96:0] p;
      logic [5:0]  c;
      bit          ev, erdy;
      logic [5:0]  ectrl;
      bit          cp;
      logic [96:0] ep;
      logic [15:0] es;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit r, bit f, bit iv, bit orr, logic [96:0] p, logic [5:0] c,
                              bit ev, bit erdy, logic [5:0] ectrl, bit cp,
                              logic [96:0] ep, logic [15:0] es);
      vec_t x;
      x.r = r; x.f = f; x.iv = iv; x.orr = orr; x.p = p; x.c = c;
      x.ev = ev; x.erdy = erdy; x.ectrl = ectrl; x.cp = cp; x.ep = ep; x.es = es;
      return x;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input bit orr);
      ent_t h;
      chk("s1_out_valid", s1_out_valid, q1.size() > 0);
      chk("s1_in_ready", s1_in_ready, q1.size() < 2);
      chk("s1_stall_cnt", s1_stall, cnt1);
      if (q1.size() > 0) begin
         h = q1[0];
         chk("s1_out_payload", s1_out_payload, h.p);
         chk("s1_out_ctrl", s1_out_ctrl, h.c);
      end else begin
         chk("s1_bubble_ctrl", s1_out_ctrl, 0);
      end
      chk("s0_out_valid", s0_out_valid, q0.size() > 0);
      chk("s0_in_ready", s0_in_ready, (q0.size() == 0) || orr);
      chk("s0_stall_cnt", s0_stall, cnt0);
      if (q0.size() > 0) begin
         h = q0[0];
         chk("s0_out_payload", s0_out_payload, h.p);
         chk("s0_out_ctrl", s0_out_ctrl, h.c);
      end else begin
         chk("s0_bubble_ctrl", s0_out_ctrl, 0);
      end
   endtask

   // One clock: drive inputs, step the model across the edge, compare after it
   task automatic cycle(input bit r, input bit f, input bit iv, input bit orr,
                        input logic [96:0] p, input logic [5:0] c);
      bit   rdy1, rdy0;
      ent_t e;
      rst = r; flush = f; in_valid = iv; out_ready = orr; in_payload = p; in_ctrl = c;
      rdy1 = q1.size() < 2;
      rdy0 = (q0.size() == 0) || orr;
      #1;
      if (!r) chk("s0_in_ready_comb", s0_in_ready, rdy0);
      @(posedge clk);
      #1;
      e.p = p;
      e.c = c;
      if (r) begin
         q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
      end else if (f) begin
         q1.delete(); q0.delete();
      end else begin
         if (q1.size() > 0 && !orr && cnt1 < 65535) cnt1++;
         if (q0.size() > 0 && !orr && cnt0 < 15) cnt0++;
         if (q1.size() > 0 && orr) void'(q1.pop_front());
         if (q0.size() > 0 && orr) void'(q0.pop_front());
         if (iv && rdy1) q1.push_back(e);
         if (iv && rdy0) q0.push_back(e);
      end
      check_model(orr);
   endtask

   initial begin
      vec_t        t;
      logic [127:0] rnd;

      // Directed table for the SKID=1 instance
      tbl.push_back(v(1,0,0,1, 0,0,           0,1,0,    1,0,0));
      for (int unsigned i = 0; i < 8; i++)
         tbl.push_back(v(0,0,1,1, 97'(i),6'h3F, 1,1,6'h3F,1,97'(i),0));
      tbl.push_back(v(0,0,0,1, 0,0,           0,1,0,    0,0,0));
      tbl.push_back(v(0,0,1,1, 'hA,6'h21,     1,1,6'h21,1,'hA,0));
      tbl.push_back(v(0,0,1,0, 'hB,6'h12,     1,0,6'h21,1,'hA,1));
      tbl.push_back(v(0,0,1,0, 'hC,6'h3F,     1,0,6'h21,1,'hA,2));
      tbl.push_back(v(0,0,0,1, 0,0,           1,1,6'h12,1,'hB,2));
      tbl.push_back(v(0,0,0,1, 0,0,           0,1,0,    0,0,2));
      tbl.push_back(v(0,0,1,0, 'h1A,6'h0C,    1,1,6'h0C,1,'h1A,2));
      tbl.push_back(v(0,0,1,0, 'h1B,6'h0C,    1,0,6'h0C,1,'h1A,3));
      tbl.push_back(v(0,1,1,0, 'h1C,6'h3F,    0,1,0,    0,0,3));
      tbl.push_back(v(0,0,0,1, 0,6'h0C,       0,1,0,    0,0,3));
      tbl.push_back(v(0,0,0,0, 0,6'h0C,       0,1,0,    0,0,3));
      tbl.push_back(v(0,0,1,0, 'h2A,6'h3F,    1,1,6'h3F,1,'h2A,3));
      tbl.push_back(v(0,0,0,0, 0,0,           1,1,6'h3F,1,'h2A,4));
      tbl.push_back(v(1,0,1,0, 'h2B,6'h3F,    0,1,0,    1,0,0));

      foreach (tbl[k]) begin
         t = tbl[k];
         cycle(t.r, t.f, t.iv, t.orr, t.p, t.c);
         chk("tbl_out_valid", s1_out_valid, t.ev);
         chk("tbl_in_ready", s1_in_ready, t.erdy);
         chk("tbl_out_ctrl", s1_out_ctrl, t.ectrl);
         chk("tbl_stall_cnt", s1_stall, t.es);
         if (t.cp) chk("tbl_out_payload", s1_out_payload, t.ep);
      end

      // SKID=0: in_ready follows out_ready within the cycle while full
      cycle(0,0,1,1, 'h55, 6'h3F);
      out_ready = 1'b0;
      #1 chk("s0_ready_follows_low", s0_in_ready, 0);
      out_ready = 1'b1;
      #1 chk("s0_ready_follows_high", s0_in_ready, 1);

      // 4-bit stall counter saturates at 15 and holds
      cycle(1,0,0,1, 0, 0);
      cycle(0,0,1,0, 'h77, 6'h3F);
      repeat (20) cycle(0,0,0,0, 0, 0);
      chk("s0_stall_sat", s0_stall, 15);
      repeat (3) cycle(0,0,0,0, 0, 0);
      chk("s0_stall_sat_hold", s0_stall, 15);
      chk("s1_stall_23", s1_stall, 23);

      // Randomized traffic against the model
      cycle(1,0,0,1, 0, 0);
      for (int unsigned i = 0; i < 400; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
               rnd[96:0], 6'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
